// File: rtl/kernel_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : kernel_bank_if
// Brief    : Host write port and coefficient stream bundle for kernel_bank.
// Revision : 1.0 - initial release
// ============================================================================
interface kernel_bank_if #(
    parameter int COEF_W      = 9,
    parameter int KSIZE       = 3,
    parameter int NUM_KERNELS = 4,
    parameter int KSEL_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    parameter int ADDR_W      = $clog2(KSIZE*KSIZE)
);
    logic                     wr_en;
    logic [KSEL_W-1:0]        wr_kernel;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [COEF_W-1:0] wr_data;
    logic                     wr_err;
    logic                     start;
    logic [KSEL_W-1:0]        kernel_sel;
    logic                     busy;
    logic signed [COEF_W-1:0] out_data;
    logic [ADDR_W-1:0]        out_idx;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        output wr_en, wr_kernel, wr_addr, wr_data, start, kernel_sel, out_ready,
        input  wr_err, busy, out_data, out_idx, out_valid, out_last
    );

    modport slave (
        input  wr_en, wr_kernel, wr_addr, wr_data, start, kernel_sel, out_ready,
        output wr_err, busy, out_data, out_idx, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/kernel_bank.sv
`default_nettype none
// ============================================================================
// Module   : kernel_bank
// Brief    : Writable multi-kernel coefficient store streaming one kernel in
//            raster order over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_bank #(
    parameter int COEF_W      = 9,
    parameter int KSIZE       = 3,
    parameter int NUM_KERNELS = 4,
    parameter int KSEL_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    parameter int ADDR_W      = $clog2(KSIZE*KSIZE)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    kernel_bank_if.slave       bus
);
    localparam int                c_KK   = KSIZE*KSIZE;
    localparam logic [KSEL_W:0]   c_NK   = (KSEL_W+1)'(NUM_KERNELS);
    localparam logic [ADDR_W:0]   c_KK_W = (ADDR_W+1)'(c_KK);
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(c_KK-1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [COEF_W-1:0] r_coef [NUM_KERNELS][c_KK];
    logic [KSEL_W-1:0]        r_sel;
    logic [ADDR_W-1:0]        r_idx;
    logic signed [COEF_W-1:0] r_data;
    logic                     r_last;
    logic                     r_wr_err;

    logic                     w_wr_ok;
    logic                     w_hs;
    logic                     w_start_ok;
    logic                     w_load;
    logic [KSEL_W-1:0]        w_load_kernel;
    logic [ADDR_W-1:0]        w_load_idx;
    logic signed [COEF_W-1:0] w_load_data;

    // Reset image: Laplacian in kernel 0, zeros elsewhere.
    function automatic logic signed [COEF_W-1:0] f_default(input int k, input int a);
        int row;
        int col;
        int ctr;
        ctr = KSIZE / 2;
        row = a / KSIZE;
        col = a % KSIZE;
        if (k != 0)
            return '0;
        if (row == ctr && col == ctr)
            return COEF_W'(4);
        if ((row == ctr && (col == ctr-1 || col == ctr+1)) ||
            (col == ctr && (row == ctr-1 || row == ctr+1)))
            return '1;
        return '0;
    endfunction

    // The streaming kernel is write-protected, so only other kernels change mid-stream.
    assign w_wr_ok = bus.wr_en
                  && ({1'b0, bus.wr_kernel} < c_NK)
                  && ({1'b0, bus.wr_addr} < c_KK_W)
                  && !(r_state == S_STREAM && bus.wr_kernel == r_sel);

    assign w_hs       = (r_state == S_STREAM) && bus.out_ready;
    assign w_start_ok = bus.start && ({1'b0, bus.kernel_sel} < c_NK);

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_load_kernel = r_sel;
        w_load_idx    = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt   = S_STREAM;
                    w_load        = 1'b1;
                    w_load_kernel = bus.kernel_sel;
                    w_load_idx    = '0;
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    if (r_idx == c_LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load     = 1'b1;
                        w_load_idx = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Forward a same-cycle write so a start sees the coefficient written with it.
    always_comb begin
        w_load_data = r_coef[w_load_kernel][w_load_idx];
        if (w_wr_ok && bus.wr_kernel == w_load_kernel && bus.wr_addr == w_load_idx)
            w_load_data = bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_KERNELS; k++)
                for (int a = 0; a < c_KK; a++)
                    r_coef[k][a] <= f_default(k, a);
        end else if (w_wr_ok) begin
            r_coef[bus.wr_kernel][bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_last   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= bus.wr_en && !w_wr_ok;
            if (r_state == S_IDLE && w_start_ok)
                r_sel <= bus.kernel_sel;
            if (w_load) begin
                r_idx  <= w_load_idx;
                r_data <= w_load_data;
                r_last <= (w_load_idx == c_LAST);
            end else if (w_hs) begin
                r_last <= 1'b0;
            end
        end
    end

    assign bus.busy      = (r_state == S_STREAM);
    assign bus.out_valid = (r_state == S_STREAM);
    assign bus.out_data  = r_data;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = r_last;
    assign bus.wr_err    = r_wr_err;
endmodule
`default_nettype wire

// File: tb/tb_kernel_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_kernel_bank
// Brief    : Directed self-checking bench for kernel_bank with a snapshot model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_bank;
    localparam int NK = 4;
    localparam int KK = 9;

    logic clk;
    logic rst;
    int   n_total = 0;
    int   n_pass  = 0;
    int   lap [KK] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    int   cap [KK];

    kernel_bank_if #(.COEF_W(9), .KSIZE(3), .NUM_KERNELS(NK)) bus ();
    kernel_bank #(.COEF_W(9), .KSIZE(3), .NUM_KERNELS(NK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    // Model: a stream replays a snapshot of the kernel taken when start is accepted.
    logic signed [8:0] mc   [NK][KK];
    logic signed [8:0] snap [KK];
    bit  m_busy;
    bit  m_err;
    int  m_sel;
    int  m_pos;

    task automatic model_reset();
        for (int k = 0; k < NK; k++)
            for (int a = 0; a < KK; a++)
                mc[k][a] = (k == 0) ? 9'(lap[a]) : 9'sd0;
        for (int a = 0; a < KK; a++)
            snap[a] = 9'sd0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_sel  = 0;
        m_pos  = 0;
    endtask

    task automatic model_step();
        m_err = 1'b0;
        if (bus.wr_en) begin
            if (int'(bus.wr_kernel) < NK && int'(bus.wr_addr) < KK &&
                !(m_busy && int'(bus.wr_kernel) == m_sel))
                mc[bus.wr_kernel][bus.wr_addr] = bus.wr_data;
            else
                m_err = 1'b1;
        end
        if (m_busy) begin
            if (bus.out_ready) begin
                if (m_pos == KK-1) m_busy = 1'b0;
                else               m_pos++;
            end
        end else if (bus.start && int'(bus.kernel_sel) < NK) begin
            m_busy = 1'b1;
            m_sel  = int'(bus.kernel_sel);
            m_pos  = 0;
            for (int a = 0; a < KK; a++)
                snap[a] = mc[m_sel][a];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    always @(negedge clk) begin
        chk("busy",   int'(bus.busy),      int'(m_busy));
        chk("valid",  int'(bus.out_valid), int'(m_busy));
        chk("last",   int'(bus.out_last),  int'(m_busy && m_pos == KK-1));
        chk("wr_err", int'(bus.wr_err),    int'(m_err));
        chk("idx",    int'(bus.out_idx),   m_pos);
        chk("data",   int'(bus.out_data),  int'(snap[m_pos]));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input int a, input int d);
        bus.wr_en     = 1'b1;
        bus.wr_kernel = 2'(k);
        bus.wr_addr   = 4'(a);
        bus.wr_data   = 9'(d);
        tick();
        bus.wr_en     = 1'b0;
    endtask

    // Entered just after a rising edge; returns at the negedge showing the final beat.
    task automatic capture(input int sel);
        int n;
        bus.start      = 1'b1;
        bus.kernel_sel = 2'(sel);
        bus.out_ready  = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        for (int c = 0; c < 30 && n < KK; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                cap[bus.out_idx] = int'(bus.out_data);
                n++;
            end
        end
        chk("capture_beats", n, KK);
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (bus.busy && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk(name, int'(bus.busy), 0);
    endtask

    initial begin
        int hs;
        bus.wr_en = 1'b0; bus.wr_kernel = '0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.kernel_sel = '0; bus.out_ready = 1'b1;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",  int'(bus.busy), 0);
        chk("reset_valid", int'(bus.out_valid), 0);
        chk("reset_data",  int'(bus.out_data), 0);
        rst = 1'b1;
        tick();

        // Default Laplacian at full rate
        capture(0);
        for (int i = 0; i < KK; i++)
            chk("lap_coef", cap[i], lap[i]);
        @(negedge clk);
        chk("lap_busy_after", int'(bus.busy), 0);
        tick();

        // Backpressure with ready pattern 1,0,0
        hs = 0;
        for (int c = 0; c < 40; c++) begin
            bus.start      = (c == 0);
            bus.kernel_sel = 2'd0;
            bus.out_ready  = (c % 3 == 0);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (hs < KK) chk("bp_beat", int'(bus.out_data), lap[hs]);
                hs++;
            end
            tick();
        end
        chk("bp_handshakes", hs, KK);
        chk("bp_idle", int'(bus.busy), 0);
        bus.start = 1'b0;
        bus.out_ready = 1'b1;

        // Extreme values round-trip
        wr(2, 4, -256);
        wr(2, 0, 255);
        capture(2);
        chk("k2_0", cap[0], 255);
        chk("k2_4", cap[4], -256);
        chk("k2_8", cap[8], 0);
        tick();

        // Write conflicts during a stalled kernel 1 stream
        bus.start = 1'b1; bus.kernel_sel = 2'd1; bus.out_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        wr(1, 3, 5);
        @(negedge clk);
        chk("conflict_err", int'(bus.wr_err), 1);
        tick();
        wr(3, 3, 7);
        @(negedge clk);
        chk("other_kernel_ok", int'(bus.wr_err), 0);
        tick();
        wr(3, 9, 11);
        @(negedge clk);
        chk("addr_range_err", int'(bus.wr_err), 1);
        tick();
        bus.out_ready = 1'b1;
        wait_idle("k1_done");
        tick();
        capture(1);
        chk("k1_3_unchanged", cap[3], 0);
        tick();
        capture(3);
        chk("k3_3", cap[3], 7);
        tick();

        // Start held through a stream: only honoured once busy is low
        bus.start = 1'b1; bus.kernel_sel = 2'd0; bus.out_ready = 1'b1;
        tick();
        bus.kernel_sel = 2'd2;
        for (int i = 0; i < KK; i++) begin
            @(negedge clk);
            if (i == 4) chk("held_start_beat4", int'(bus.out_data), 4);
        end
        @(negedge clk);
        chk("restart_gap_busy", int'(bus.busy), 0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("restart_busy", int'(bus.busy), 1);
        chk("restart_data", int'(bus.out_data), 255);
        wait_idle("restart_done");
        tick();

        // Asynchronous reset mid-stream restores defaults
        wr(0, 4, 9);
        bus.start = 1'b1; bus.kernel_sel = 2'd0; bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_beat4", int'(bus.out_data), 9);
        #1 rst = 1'b0;
        #1;
        chk("arst_busy",  int'(bus.busy), 0);
        chk("arst_valid", int'(bus.out_valid), 0);
        chk("arst_last",  int'(bus.out_last), 0);
        chk("arst_data",  int'(bus.out_data), 0);
        chk("arst_idx",   int'(bus.out_idx), 0);
        tick();
        rst = 1'b1;
        tick();
        capture(0);
        chk("post_reset_4", cap[4], 4);
        chk("post_reset_1", cap[1], -1);
        @(negedge clk);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
